// File: rtl/storage_pkg.sv
// Shared storage-subsystem definitions: DMA state encoding, bridge lane indices,
// region bases and word-to-byte address helpers.
package storage_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } dma_state_e;

  localparam int LANE_RW = 0;
  localparam int LANE_RO = 1;

  localparam logic [23:0] STORAGE_RO_BASE  = 24'h20_0000;
  localparam logic [23:0] STORAGE_RW_BASE0 = 24'h00_0000;
  localparam logic [23:0] STORAGE_RW_BASE1 = 24'h10_0000;

  localparam int WAIT_W = 8;

  // RO region keeps only its top byte; the word index lands on bits [9:2].
  function automatic logic [31:0] ro_word_adr(input logic [23:0] base, input logic [7:0] idx);
    return {8'h00, base[23:16], 6'h00, idx, 2'b00};
  endfunction

  function automatic logic [31:0] rw_word_adr(input logic [23:0] base, input logic [8:0] idx);
    return {8'h00, base | {13'h0000, idx, 2'b00}};
  endfunction

endpackage

// File: rtl/storage_dma_timeout.sv
// Ack wait counter for the storage DMA: cleared on each bus phase entry,
// counts stalled cycles and flags expiry at TIMEOUT-1.
module storage_dma_timeout
  import storage_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  logic [WAIT_W-1:0] cnt_q;
  logic [WAIT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + {{(WAIT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == WAIT_W'(TIMEOUT - 1));

endmodule

// File: rtl/storage_dma_wb.sv
// Wishbone DMA master copying words from the RO storage region into an R/W
// block, one read/write pair per word through the two-lane storage bridge.
module storage_dma_wb
  import storage_pkg::*;
#(
  parameter logic [23:0] RO_BASE  = STORAGE_RO_BASE,
  parameter logic [23:0] RW_BASE0 = STORAGE_RW_BASE0,
  parameter logic [23:0] RW_BASE1 = STORAGE_RW_BASE1,
  parameter int          TIMEOUT  = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n,
  input  logic        start_i,
  input  logic [7:0]  src_word_i,
  input  logic        dst_blk_i,
  input  logic [8:0]  dst_word_i,
  input  logic [8:0]  len_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic        wbm_cyc_o,
  output logic [1:0]  wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [1:0]  wbm_ack_i,
  input  logic [31:0] wbm_ro_dat_i
);

  dma_state_e  state_q, state_d;
  logic [7:0]  src_q, src_d;
  logic [8:0]  dst_q, dst_d;
  logic        blk_q, blk_d;
  logic [8:0]  len_q, len_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        cyc_q, cyc_d;
  logic [1:0]  stb_q, stb_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;

  logic        ack_rd;
  logic        ack_wr;
  logic        phase_ack;
  logic        expire;
  logic        finish;
  logic [23:0] rw_base;

  // Only the lane currently strobed can complete a phase; the other is ignored.
  assign ack_rd    = (state_q == RD) && wbm_ack_i[LANE_RO];
  assign ack_wr    = (state_q == WR) && wbm_ack_i[LANE_RW];
  assign phase_ack = ack_rd || ack_wr;
  assign rw_base   = blk_q ? RW_BASE1 : RW_BASE0;

  storage_dma_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk      (wb_clk_i),
    .rst_n    (wb_rst_n),
    .clr_i    ((state_q == IDLE) || phase_ack),
    .en_i     ((state_q != IDLE) && !phase_ack),
    .expire_o (expire)
  );

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    blk_d   = blk_q;
    len_d   = len_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    cyc_d   = cyc_q;
    stb_d   = stb_q;
    we_d    = we_q;
    sel_d   = sel_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    finish  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          src_d = src_word_i;
          dst_d = dst_word_i;
          blk_d = dst_blk_i;
          len_d = len_i;
          err_d = 1'b0;
          if (len_i == 9'd0) begin
            done_d = 1'b1;
          end else begin
            state_d = RD;
            busy_d  = 1'b1;
            cyc_d   = 1'b1;
            stb_d   = 2'b10;
            we_d    = 1'b0;
            sel_d   = 4'hF;
            adr_d   = ro_word_adr(RO_BASE, src_word_i);
          end
        end
      end

      RD: begin
        if (ack_rd) begin
          // Read data goes straight out as write data; no idle cycle between phases.
          state_d = WR;
          dat_d   = wbm_ro_dat_i;
          stb_d   = 2'b01;
          we_d    = 1'b1;
          sel_d   = 4'hF;
          adr_d   = rw_word_adr(rw_base, dst_q);
        end else if (expire) begin
          err_d  = 1'b1;
          finish = 1'b1;
        end
      end

      WR: begin
        if (ack_wr) begin
          len_d = len_q - 9'd1;
          src_d = src_q + 8'd1;
          dst_d = dst_q + 9'd1;
          if (len_q == 9'd1) begin
            finish = 1'b1;
          end else begin
            state_d = RD;
            stb_d   = 2'b10;
            we_d    = 1'b0;
            sel_d   = 4'hF;
            adr_d   = ro_word_adr(RO_BASE, src_q + 8'd1);
          end
        end else if (expire) begin
          err_d  = 1'b1;
          finish = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (finish) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b1;
      cyc_d   = 1'b0;
      stb_d   = 2'b00;
      we_d    = 1'b0;
      sel_d   = 4'h0;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      blk_q   <= 1'b0;
      len_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cyc_q   <= 1'b0;
      stb_q   <= 2'b00;
      we_q    <= 1'b0;
      sel_q   <= 4'h0;
      adr_q   <= '0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      blk_q   <= blk_d;
      len_q   <= len_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign err_o     = err_q;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = stb_q;
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = sel_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;

endmodule
